fp_cmp_pipe: RTL and testbench
==============================

# fp_cmp_pipe

Pipelined, parametrised floating-point compare/select unit for the FPU execute stage. It covers FEQ/FLT/FLE and adds FMIN/FMAX with RISC-V NaN and signed-zero semantics. A valid/ready handshake with per-stage backpressure carries a caller tag alongside each result, and the block keeps a sticky accumulated invalid flag for fflags writeback.

## Interface
- FLEN, default 64: operand format width; data is FLEN+1 bits, sign at bit FLEN, exponent+mantissa in [FLEN-1:0].
- STAGES, default 2: pipeline depth, legal range 1..4.
- TAG_W, default 5: width of the passthrough tag (e.g. rd index).
- CANON_NAN, default 65'h0_7FF8_0000_0000_0000: FLEN+1-bit canonical NaN; set to 33'h0_7FC0_0000 for FLEN=32.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  stage 1 can accept this cycle.
- op_in  in  3  0 FLE, 1 FLT, 2 FEQ, 4 FMIN, 5 FMAX; 3/6/7 reserved.
- data1_in, data2_in  in  FLEN+1  operands.
- class1_in, class2_in  in  10  fclass one-hot: bit3 -0, bit4 +0, bit8 sNaN, bit9 qNaN.
- tag_in  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result_out  out  FLEN+1  compare: bit0 = outcome, other bits 0; FMIN/FMAX: selected value.
- flags_out  out  5  per-op exception flags; only bit4 (NV) is ever set.
- tag_out  out  TAG_W  tag of the result.
- flags_acc  out  5  sticky OR of retired flags_out.
- flags_clr  in  1  clear flags_acc.

## Operation
- Magnitude compare is unsigned on [FLEN-1:0].
- Ordering, non-NaN operands:
  - ±0 pair: compares equal.
  - Different signs: negative is lower.
  - Both positive: use magnitude order.
  - Both negative: use inverted magnitude order.
- FEQ: NV only if either operand is sNaN. Result is 0 if either operand is NaN, else equality.
- FLT/FLE: NV and result 0 if either operand is any NaN. Otherwise strict or non-strict ordering.
- FMIN/FMAX:
  - NV if either operand is sNaN.
  - Both NaN: result is CANON_NAN.
  - Exactly one NaN: result is the other operand, verbatim.
  - Otherwise select the lower (FMIN) or higher (FMAX) operand.
  - Signed zero: -0 is treated as lower than +0, so FMIN(+0,-0) = -0 and FMAX(-0,+0) = +0.
- Reserved op: result 0, flags 0, tag passes normally.
- The result is computed combinationally from the inputs and captured in stage 1. Stages 2..STAGES are delay registers holding {valid, result, flags, tag}.
- Stage advance rule: stage k loads from stage k-1 when stage k is empty or stage k is draining this cycle.
  - in_ready = stage 1 empty, or stage 1 advances this cycle. It is combinational from out_ready through the chain.
  - A transfer occurs only when in_valid and in_ready are both high. The input is ignored otherwise.
  - Bubbles collapse: a full stage behind an empty stage advances even while out_ready is low.
- Output-stage registers hold their value while out_valid is high and out_ready is low.
- flags_acc next value = (flags_clr ? 0 : flags_acc) | (out_valid & out_ready ? flags_out : 0). A same-cycle retire is therefore not lost on clear.

## Timing
- Reset values: all stage valids 0, out_valid 0, result_out 0, flags_out 0, tag_out 0, flags_acc 0.
- in_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation discards every in-flight op; no flags from those ops reach flags_acc.
- Latency: an op accepted at edge N has out_valid high after edge N+STAGES-1 when unstalled. For STAGES=1 it appears after the accepting edge.
- Throughput: one op per cycle with out_ready held high.
- Full pipe with out_ready low: in_ready is 0. When out_ready rises, in_ready rises in the same cycle.
- flags_acc updates one edge after the retire or clear.

## Test plan
- Compare ops, FLEN=64, STAGES=2, out_ready=1:
  - FLT(-1.0 = 65'h1_3FF0_0000_0000_0000, +2.0 = 65'h0_4000_0000_0000_0000) -> result 1, flags 0, after 2 edges.
  - FLE(+0, -0) -> 1.
  - FLT(+0, -0) -> 0.
- NaN handling:
  - FEQ(qNaN, 1.0) -> result 0, flags 0.
  - FEQ(sNaN, 1.0) -> result 0, flags 5'b10000.
  - FLE(qNaN, 1.0) -> result 0, flags 5'b10000.
- Min/max:
  - FMIN(qNaN, 3.0) -> 3.0, flags 0.
  - FMAX(sNaN, qNaN) -> CANON_NAN, flags 5'b10000.
  - FMIN(+0, -0) -> 65'h1_0000_0000_0000_0000.
- Backpressure, STAGES=3:
  - Stream 6 tagged ops while holding out_ready=0 for 5 cycles -> in_ready drops after 3 accepts; no op lost or duplicated; tags retire in order 0..5.
- Sticky flags:
  - Retire NV op -> flags_acc = 5'b10000.
  - flags_clr together with a same-cycle NV retire -> flags_acc stays 5'b10000.
  - flags_clr alone -> flags_acc = 0.
- Reset mid-stream:
  - Assert rst with 2 ops in flight -> next cycle out_valid=0, flags_acc=0; a subsequent op completes with normal latency.

Source files
------------

// File: rtl/fp_cmp_pipe.sv
// Pipelined FP compare/select unit: FEQ/FLT/FLE/FMIN/FMAX with RISC-V NaN and signed-zero rules.
// Result is formed combinationally, captured in stage 1, then carried through elastic delay stages.
module fp_cmp_pipe #(
  parameter int unsigned   FLEN      = 64,
  parameter int unsigned   STAGES    = 2,
  parameter int unsigned   TAG_W     = 5,
  parameter logic [FLEN:0] CANON_NAN = 65'h0_7FF8_0000_0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_in,
  input  logic [FLEN:0]    data1_in,
  input  logic [FLEN:0]    data2_in,
  input  logic [9:0]       class1_in,
  input  logic [9:0]       class2_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLEN:0]    result_out,
  output logic [4:0]       flags_out,
  output logic [TAG_W-1:0] tag_out,
  output logic [4:0]       flags_acc,
  input  logic             flags_clr
);

  localparam logic [2:0] OP_FLE  = 3'd0;
  localparam logic [2:0] OP_FLT  = 3'd1;
  localparam logic [2:0] OP_FEQ  = 3'd2;
  localparam logic [2:0] OP_FMIN = 3'd4;
  localparam logic [2:0] OP_FMAX = 3'd5;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("fp_cmp_pipe: STAGES must be in 1..4");
  end

  logic            nan1, nan2, snan1, snan2, zero_pair;
  logic            mag_lt, mag_eq, lt, eq, a_lower, nv;
  logic [FLEN:0]   res_c;
  logic [4:0]      flags_c;

  // Only the NaN and zero classes matter here; the rest are ignored.
  logic unused_class;
  assign unused_class = ^{class1_in[7:5], class1_in[2:0], class2_in[7:5], class2_in[2:0]};

  always_comb begin
    nan1      = class1_in[8] | class1_in[9];
    nan2      = class2_in[8] | class2_in[9];
    snan1     = class1_in[8];
    snan2     = class2_in[8];
    zero_pair = (class1_in[3] | class1_in[4]) & (class2_in[3] | class2_in[4]);
    mag_lt    = data1_in[FLEN-1:0] < data2_in[FLEN-1:0];
    mag_eq    = data1_in[FLEN-1:0] == data2_in[FLEN-1:0];
    lt        = 1'b0;
    eq        = 1'b0;
    if (zero_pair) begin
      eq = 1'b1;
    end else if (data1_in[FLEN] != data2_in[FLEN]) begin
      lt = data1_in[FLEN];
    end else if (!data1_in[FLEN]) begin
      lt = mag_lt;
      eq = mag_eq;
    end else begin
      lt = !mag_lt && !mag_eq;
      eq = mag_eq;
    end
    // For min/max, -0 sits below +0 even though they compare equal.
    a_lower = zero_pair ? data1_in[FLEN] : lt;
    nv      = 1'b0;
    res_c   = '0;
    unique case (op_in)
      OP_FLE: begin
        nv       = nan1 | nan2;
        res_c[0] = !(nan1 | nan2) && (lt || eq);
      end
      OP_FLT: begin
        nv       = nan1 | nan2;
        res_c[0] = !(nan1 | nan2) && lt;
      end
      OP_FEQ: begin
        nv       = snan1 | snan2;
        res_c[0] = !(nan1 | nan2) && eq;
      end
      OP_FMIN, OP_FMAX: begin
        nv = snan1 | snan2;
        if (nan1 && nan2)             res_c = CANON_NAN;
        else if (nan1)                res_c = data2_in;
        else if (nan2)                res_c = data1_in;
        else if (a_lower == (op_in == OP_FMIN)) res_c = data1_in;
        else                          res_c = data2_in;
      end
      default: ;
    endcase
    flags_c = {nv, 4'b0000};
  end

  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] adv;
  logic [FLEN:0]     st_res [STAGES];
  logic [4:0]        st_flg [STAGES];
  logic [TAG_W-1:0]  st_tag [STAGES];

  // A stage may load when it, or any stage downstream of it, has a free slot or the output drains.
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    assign adv[k] = out_ready | ~(&st_valid[STAGES-1:k]);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_valid;
    logic [FLEN:0]    src_res;
    logic [4:0]       src_flg;
    logic [TAG_W-1:0] src_tag;
    logic             valid_q;
    logic [FLEN:0]    res_q;
    logic [4:0]       flg_q;
    logic [TAG_W-1:0] tag_q;

    if (k == 0) begin : g_first
      assign src_valid = in_valid;
      assign src_res   = res_c;
      assign src_flg   = flags_c;
      assign src_tag   = tag_in;
    end else begin : g_next
      assign src_valid = st_valid[k-1];
      assign src_res   = st_res[k-1];
      assign src_flg   = st_flg[k-1];
      assign src_tag   = st_tag[k-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        res_q   <= '0;
        flg_q   <= '0;
        tag_q   <= '0;
      end else if (adv[k]) begin
        valid_q <= src_valid;
        if (src_valid) begin
          res_q <= src_res;
          flg_q <= src_flg;
          tag_q <= src_tag;
        end
      end
    end

    assign st_valid[k] = valid_q;
    assign st_res[k]   = res_q;
    assign st_flg[k]   = flg_q;
    assign st_tag[k]   = tag_q;
  end

  assign in_ready   = adv[0];
  assign out_valid  = st_valid[STAGES-1];
  assign result_out = st_res[STAGES-1];
  assign flags_out  = st_flg[STAGES-1];
  assign tag_out    = st_tag[STAGES-1];

  // Clear and a same-cycle retire combine so the retiring op's flags survive.
  always_ff @(posedge clk) begin
    if (rst) flags_acc <= '0;
    else     flags_acc <= (flags_clr ? 5'b00000 : flags_acc) | ((out_valid && out_ready) ? flags_out : 5'b00000);
  end

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Bench for fp_cmp_pipe: directed vectors, backpressure, sticky flags, reset, and a random run
// checked against a real-arithmetic reference model with per-instance result queues.
module tb_fp_cmp_pipe;

  localparam logic [64:0] CANON = 65'h0_7FF8_0000_0000_0000;
  localparam logic [64:0] ONE   = 65'h0_3FF0_0000_0000_0000;
  localparam logic [64:0] M1    = 65'h1_3FF0_0000_0000_0000;
  localparam logic [64:0] TWO   = 65'h0_4000_0000_0000_0000;
  localparam logic [64:0] THREE = 65'h0_4008_0000_0000_0000;
  localparam logic [64:0] PZ    = 65'h0_0000_0000_0000_0000;
  localparam logic [64:0] MZ    = 65'h1_0000_0000_0000_0000;
  localparam logic [64:0] QN    = 65'h0_7FF8_0000_0000_0000;
  localparam logic [64:0] SN    = 65'h0_7FF4_0000_0000_0000;

  localparam int NDIR = 13;
  localparam logic [2:0]  DOP [NDIR] = '{3'd1, 3'd0, 3'd1, 3'd2, 3'd2, 3'd0, 3'd4, 3'd5, 3'd4, 3'd5, 3'd2, 3'd5, 3'd3};
  localparam logic [64:0] DA  [NDIR] = '{M1, PZ, PZ, QN, SN, QN, QN, SN, PZ, MZ, ONE, M1, ONE};
  localparam logic [64:0] DB  [NDIR] = '{TWO, MZ, MZ, ONE, ONE, ONE, THREE, QN, MZ, PZ, ONE, TWO, TWO};
  localparam logic [64:0] DR  [NDIR] = '{65'd1, 65'd1, 65'd0, 65'd0, 65'd0, 65'd0, THREE, CANON, MZ, PZ, 65'd1, TWO, 65'd0};
  localparam logic [4:0]  DF  [NDIR] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd16, 5'd16, 5'd0, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
  localparam logic [63:0] POOL [4] = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
                                       64'h0000_0000_0000_0001, 64'h7FEF_FFFF_FFFF_FFFF};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        flags_clr = 1'b0;
  logic [2:0]  op_in = '0;
  logic [64:0] data1_in = '0, data2_in = '0;
  logic [9:0]  class1_in = '0, class2_in = '0;
  logic [4:0]  tag_in = '0;

  logic        in_ready2, out_valid2, in_ready3, out_valid3;
  logic [64:0] result2, result3;
  logic [4:0]  flags2, flags3, tag2, tag3, acc2, acc3;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [64:0] res;
    logic [4:0]  flg;
    logic [4:0]  tag;
  } exp_t;

  fp_cmp_pipe #(.FLEN(64), .STAGES(2), .TAG_W(5), .CANON_NAN(CANON)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .op_in(op_in),
    .data1_in(data1_in), .data2_in(data2_in), .class1_in(class1_in), .class2_in(class2_in),
    .tag_in(tag_in), .out_valid(out_valid2), .out_ready(out_ready), .result_out(result2),
    .flags_out(flags2), .tag_out(tag2), .flags_acc(acc2), .flags_clr(flags_clr));

  fp_cmp_pipe #(.FLEN(64), .STAGES(3), .TAG_W(5), .CANON_NAN(CANON)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .op_in(op_in),
    .data1_in(data1_in), .data2_in(data2_in), .class1_in(class1_in), .class2_in(class2_in),
    .tag_in(tag_in), .out_valid(out_valid3), .out_ready(out_ready), .result_out(result3),
    .flags_out(flags3), .tag_out(tag3), .flags_acc(acc3), .flags_clr(flags_clr));

  always #5 clk = ~clk;

  function automatic logic is_nan(input logic [64:0] d);
    return (d[62:52] == 11'h7FF) && (d[51:0] != 52'd0);
  endfunction

  function automatic logic [9:0] fclass(input logic [64:0] d);
    logic [9:0] c;
    c = '0;
    if (is_nan(d))                              c[d[51] ? 9 : 8] = 1'b1;
    else if (d[62:52] == 11'h7FF)               c[d[64] ? 0 : 7] = 1'b1;
    else if (d[62:0] == 63'd0)                  c[d[64] ? 3 : 4] = 1'b1;
    else if (d[62:52] == 11'h000)               c[d[64] ? 2 : 5] = 1'b1;
    else                                        c[d[64] ? 1 : 6] = 1'b1;
    return c;
  endfunction

  // Reference: orders operands as reals, NaN/zero rules stated directly.
  function automatic void ref_op(input logic [2:0] op, input logic [64:0] a, input logic [64:0] b,
                                 output logic [64:0] res, output logic [4:0] flg);
    real va, vb;
    logic na, nb, sa, sb;
    na = is_nan(a); nb = is_nan(b);
    sa = na && !a[51]; sb = nb && !b[51];
    va = $bitstoreal({1'b0, a[62:0]}); if (a[64]) va = -va;
    vb = $bitstoreal({1'b0, b[62:0]}); if (b[64]) vb = -vb;
    res = '0; flg = '0;
    case (op)
      3'd0: begin flg[4] = na | nb; res[0] = !(na || nb) && (va <= vb); end
      3'd1: begin flg[4] = na | nb; res[0] = !(na || nb) && (va < vb); end
      3'd2: begin flg[4] = sa | sb; res[0] = !(na || nb) && (va == vb); end
      3'd4, 3'd5: begin
        flg[4] = sa | sb;
        if (na && nb)      res = CANON;
        else if (na)       res = b;
        else if (nb)       res = a;
        else if (va == vb) res = (op == 3'd4) ? (a[64] ? a : b) : (a[64] ? b : a);
        else               res = ((va < vb) == (op == 3'd4)) ? a : b;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [64:0] rnd_operand();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       return {s, 1'b0, 11'h7FF, 1'b1, 51'({$urandom(), $urandom()})};
      1:       return {s, 1'b0, 11'h7FF, 1'b0, 51'({$urandom(), $urandom()}) | 51'd1};
      2:       return {s, 64'd0};
      3:       return {s, 1'b0, 11'h7FF, 52'd0};
      4, 5, 6: return {s, POOL[$urandom_range(0, 3)]};
      default: return {s, 1'b0, 11'($urandom_range(0, 2046)), 52'({$urandom(), $urandom()})};
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic [64:0] a, input logic [64:0] b, input logic [4:0] t);
    op_in = op; data1_in = a; data2_in = b;
    class1_in = fclass(a); class2_in = fclass(b); tag_in = t;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; flags_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_chk++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid2); end
    n_chk++; if (result2 !== 65'd0)   begin n_fail++; $display("FAIL reset_result: got %h want 0", result2); end
    n_chk++; if (flags2 !== 5'd0)     begin n_fail++; $display("FAIL reset_flags: got %b want 0", flags2); end
    n_chk++; if (tag2 !== 5'd0)       begin n_fail++; $display("FAIL reset_tag: got %0d want 0", tag2); end
    n_chk++; if (acc2 !== 5'd0)       begin n_fail++; $display("FAIL reset_flags_acc: got %b want 0", acc2); end
    n_chk++; if (in_ready2 !== 1'b1 || in_ready3 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready2, in_ready3); end
  endtask

  task automatic test_directed_ops();
    out_ready = 1'b1;
    for (int i = 0; i < NDIR; i++) begin
      @(posedge clk); #1;
      drive(DOP[i], DA[i], DB[i], 5'(i)); in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      n_chk++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid2); end
      @(negedge clk);
      n_chk++; if (out_valid2 !== 1'b1 || result2 !== DR[i] || flags2 !== DF[i] || tag2 !== 5'(i)) begin
        n_fail++; $display("FAIL dir%0d_s2: got v=%b r=%h f=%b t=%0d want v=1 r=%h f=%b t=%0d",
                           i, out_valid2, result2, flags2, tag2, DR[i], DF[i], i); end
      @(negedge clk);
      n_chk++; if (out_valid3 !== 1'b1 || result3 !== DR[i] || flags3 !== DF[i]) begin
        n_fail++; $display("FAIL dir%0d_s3: got v=%b r=%h f=%b want v=1 r=%h f=%b",
                           i, out_valid3, result3, flags3, DR[i], DF[i]); end
    end
  endtask

  task automatic test_backpressure();
    int idx, ret;
    apply_reset();
    out_ready = 1'b0; idx = 0; ret = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 5);
      in_valid  = (idx < 6);
      drive(3'd1, M1, TWO, 5'(idx));
      @(negedge clk);
      if (cyc == 3 || cyc == 4) begin
        n_chk++; if (in_ready3 !== 1'b0 || idx != 3) begin
          n_fail++; $display("FAIL bp_full_c%0d: got in_ready=%b accepts=%0d want 0/3", cyc, in_ready3, idx); end
      end
      if (cyc == 5) begin
        n_chk++; if (in_ready3 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b want 1", in_ready3); end
      end
      if (out_valid3 && out_ready) begin
        n_chk++; if (tag3 !== 5'(ret) || result3 !== 65'd1) begin
          n_fail++; $display("FAIL bp_retire%0d: got tag=%0d r=%h want tag=%0d r=1", ret, tag3, result3, ret); end
        ret++;
      end
      if (in_valid && in_ready3) idx++;
      if (ret == 6) break;
    end
    in_valid = 1'b0;
    n_chk++; if (ret != 6 || idx != 6) begin n_fail++; $display("FAIL bp_count: got retired=%0d accepted=%0d want 6/6", ret, idx); end
    repeat (4) @(negedge clk);
    n_chk++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate: got out_valid=%b want 0", out_valid3); end
  endtask

  task automatic test_sticky_flags();
    apply_reset();
    out_ready = 1'b1;
    @(posedge clk); #1; drive(3'd0, QN, ONE, 5'd7); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (acc2 !== 5'd0) begin n_fail++; $display("FAIL sticky_pre: got %b want 00000", acc2); end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (acc2 !== 5'b10000) begin n_fail++; $display("FAIL sticky_set: got %b want 10000", acc2); end
    @(posedge clk); #1; drive(3'd2, SN, ONE, 5'd8); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 flags_clr = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid2 !== 1'b1 || flags2 !== 5'b10000) begin
      n_fail++; $display("FAIL sticky_retiring: got v=%b f=%b want 1/10000", out_valid2, flags2); end
    @(posedge clk); #1 flags_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (acc2 !== 5'b10000) begin n_fail++; $display("FAIL sticky_clr_retire: got %b want 10000", acc2); end
    @(posedge clk); #1 flags_clr = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (acc2 !== 5'd0) begin n_fail++; $display("FAIL sticky_clear: got %b want 00000", acc2); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    out_ready = 1'b0;
    @(posedge clk); #1; drive(3'd0, QN, ONE, 5'd1); in_valid = 1'b1;
    @(posedge clk); #1; drive(3'd0, SN, ONE, 5'd2);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got %b want 1", out_valid2); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid2 !== 1'b0 || out_valid3 !== 1'b0 || acc2 !== 5'd0 || acc3 !== 5'd0) begin
      n_fail++; $display("FAIL mid_flush: got v=%b/%b acc=%b/%b want 0/0 0/0", out_valid2, out_valid3, acc2, acc3); end
    @(posedge clk); #1; drive(3'd1, M1, TWO, 5'd9); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL mid_latency_early: got %b want 0", out_valid2); end
    @(negedge clk);
    n_chk++; if (out_valid2 !== 1'b1 || result2 !== 65'd1 || tag2 !== 5'd9 || flags2 !== 5'd0) begin
      n_fail++; $display("FAIL mid_after: got v=%b r=%h t=%0d f=%b want 1/1/9/0", out_valid2, result2, tag2, flags2); end
  endtask

  task automatic test_random();
    exp_t q2[$], q3[$], e;
    logic [4:0] acc_m2, acc_m3, rf2, rf3;
    apply_reset();
    acc_m2 = '0; acc_m3 = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      flags_clr = ($urandom_range(0, 19) == 0);
      drive(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 5'($urandom_range(0, 31)));
      @(negedge clk);
      ref_op(op_in, data1_in, data2_in, e.res, e.flg);
      e.tag = tag_in;
      n_chk++; if (in_ready2 !== (q2.size() < 2 || out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready2 c%0d: got %b occupancy=%0d", cyc, in_ready2, q2.size()); end
      n_chk++; if (in_ready3 !== (q3.size() < 3 || out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready3 c%0d: got %b occupancy=%0d", cyc, in_ready3, q3.size()); end
      n_chk++; if (acc2 !== acc_m2 || acc3 !== acc_m3) begin
        n_fail++; $display("FAIL rnd_flags_acc c%0d: got %b/%b want %b/%b", cyc, acc2, acc3, acc_m2, acc_m3); end
      rf2 = '0; rf3 = '0;
      if (out_valid2 && out_ready) begin
        n_chk++;
        if (q2.size() == 0) begin n_fail++; $display("FAIL rnd_spurious2 c%0d: got unexpected result", cyc); end
        else begin
          if (result2 !== q2[0].res || flags2 !== q2[0].flg || tag2 !== q2[0].tag) begin
            n_fail++; $display("FAIL rnd_result2 c%0d: got r=%h f=%b t=%0d want r=%h f=%b t=%0d",
                               cyc, result2, flags2, tag2, q2[0].res, q2[0].flg, q2[0].tag); end
          rf2 = q2[0].flg; void'(q2.pop_front());
        end
      end
      if (out_valid3 && out_ready) begin
        n_chk++;
        if (q3.size() == 0) begin n_fail++; $display("FAIL rnd_spurious3 c%0d: got unexpected result", cyc); end
        else begin
          if (result3 !== q3[0].res || flags3 !== q3[0].flg || tag3 !== q3[0].tag) begin
            n_fail++; $display("FAIL rnd_result3 c%0d: got r=%h f=%b t=%0d want r=%h f=%b t=%0d",
                               cyc, result3, flags3, tag3, q3[0].res, q3[0].flg, q3[0].tag); end
          rf3 = q3[0].flg; void'(q3.pop_front());
        end
      end
      if (in_valid && in_ready2) q2.push_back(e);
      if (in_valid && in_ready3) q3.push_back(e);
      acc_m2 = (flags_clr ? 5'd0 : acc_m2) | rf2;
      acc_m3 = (flags_clr ? 5'd0 : acc_m3) | rf3;
    end
    in_valid = 1'b0; flags_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed_ops();
    test_backpressure();
    test_sticky_flags();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
